// File: rtl/datamemory_param.sv
// Word-addressed data memory with byte-lane writes, fixed-latency in-order responses,
// range checking and an optional zero-fill sweep after reset.
module datamemory_param #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 1024,
   parameter int ADDR_W         = 12,
   parameter int BASE_ADDR      = 256,
   parameter int RD_LAT         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_err,
   output logic                init_busy
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  RANGE_LO = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0]  RANGE_HI = (ADDR_W+1)'(BASE_ADDR + DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   logic [IDX_W-1:0]  sweep_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   logic [RD_LAT-1:0] pipe_vld;
   logic [RD_LAT-1:0] pipe_err;
   logic [DATA_W-1:0] pipe_dat [RD_LAT];

   // Range is checked one bit wider so BASE_ADDR+DEPTH may reach 2**ADDR_W.
   assign in_range = ({1'b0, req_addr} >= RANGE_LO) && ({1'b0, req_addr} < RANGE_HI);
   assign idx      = IDX_W'(req_addr - ADDR_W'(BASE_ADDR));
   assign accept   = req_valid && req_ready;

   // Outputs are gated by rst so they are quiet from the very first reset cycle.
   assign req_ready = (state == RUN) && !rst;
   assign init_busy = (state == CLEAR);
   assign rsp_valid = pipe_vld[RD_LAT-1] && !rst;
   assign rsp_err   = pipe_err[RD_LAT-1] && !rst;
   assign rsp_data  = rst ? '0 : pipe_dat[RD_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
         sweep_cnt <= '0;
      end else if (state == CLEAR) begin
         if (sweep_cnt == LAST_IDX) begin
            state     <= RUN;
            sweep_cnt <= '0;
         end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
         end
      end
   end

   // Storage has no reset so contents survive reset when the sweep is disabled.
   always_ff @(posedge clk) begin
      if (!rst && state == CLEAR) begin
         mem[sweep_cnt] <= '0;
      end else if (accept && req_we && in_range) begin
         for (int i = 0; i < BE_W; i++) begin
            if (req_be[i]) begin
               mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
         pipe_err <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_dat[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= accept;
         pipe_err[0] <= accept && !in_range;
         pipe_dat[0] <= (accept && !req_we && in_range) ? mem[idx] : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_err[i] <= pipe_err[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
         end
      end
   end

endmodule

// File: tb/tb_datamemory_param.sv
// Bench for datamemory_param: three instances (defaults, RD_LAT=2, no clear sweep)
// checked against a word-array reference model.
module tb_datamemory_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_we;
   logic [11:0] req_addr  [3];
   logic [3:0]  req_be    [3];
   logic [31:0] req_wdata [3];
   wire  [2:0]  req_ready;
   wire  [2:0]  rsp_valid;
   wire  [2:0]  rsp_err;
   wire  [2:0]  init_busy;
   wire  [31:0] rsp_data  [3];

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [3][1024];

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         datamemory_param #(
            .RD_LAT        ((g == 1) ? 2 : 1),
            .CLEAR_ON_RESET((g == 2) ? 0 : 1)
         ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_be   (req_be[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_data (rsp_data[g]),
            .rsp_err  (rsp_err[g]),
            .init_busy(init_busy[g])
         );
      end
   endgenerate

   // Reference: mapped window is 256..1279, writes merge enabled bytes, reads return stored word.
   function automatic logic [32:0] model_apply(input int d, input logic we, input logic [11:0] addr,
                                               input logic [3:0] be, input logic [31:0] wd);
      int a;
      a = int'(addr);
      if (a < 256 || a >= 1280) return {1'b1, 32'h0000_0000};
      if (we) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem_m[d][a-256][8*i +: 8] = wd[8*i +: 8];
         return {1'b0, 32'h0000_0000};
      end
      return {1'b0, mem_m[d][a-256]};
   endfunction

   task automatic drive(input int d, input logic v, input logic we, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
      req_valid[d] = v;
      req_we[d]    = we;
      req_addr[d]  = a;
      req_be[d]    = be;
      req_wdata[d] = wd;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 || rsp_data[d] !== 32'h0 || req_ready[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs[%0d] got v=%0b e=%0b d=%h rdy=%0b exp all 0",
                     d, rsp_valid[d], rsp_err[d], rsp_data[d], req_ready[d]);
         end
         checks++;
         if (init_busy[d] !== ((d != 2) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL reset_init_busy[%0d] got %0b exp %0b", d, init_busy[d], (d != 2));
         end
      end
   endtask

   task automatic test_sweep();
      int  busy_cnt [3];
      bit  done [3];
      for (int d = 0; d < 3; d++) begin
         busy_cnt[d] = 0;
         done[d] = 1'b0;
      end
      @(negedge clk);
      rst = 3'b000;
      for (int c = 0; c < 1100; c++) begin
         #1;
         for (int d = 0; d < 3; d++) begin
            if (!done[d]) begin
               if (init_busy[d] && !req_ready[d]) busy_cnt[d]++;
               else done[d] = 1'b1;
            end
         end
         @(negedge clk);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (busy_cnt[d] !== ((d == 2) ? 0 : 1024)) begin
            errors++;
            $display("FAIL sweep_len[%0d] got %0d exp %0d", d, busy_cnt[d], (d == 2) ? 0 : 1024);
         end
         checks++;
         if (req_ready[d] !== 1'b1 || init_busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL run_state[%0d] got rdy=%0b busy=%0b exp rdy=1 busy=0", d, req_ready[d], init_busy[d]);
         end
      end
      for (int i = 0; i < 1024; i++) begin
         mem_m[0][i] = 32'h0;
         mem_m[1][i] = 32'h0;
      end
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 12'd256, 4'h0, 32'h0);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      #1;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
         errors++;
         $display("FAIL post_sweep_read got v=%0b d=%h e=%0b exp v=1 d=00000000 e=0", rsp_valid[0], rsp_data[0], rsp_err[0]);
      end
   endtask

   task automatic test_byte_lane();
      logic        we  [3] = '{1'b1, 1'b1, 1'b0};
      logic [3:0]  be  [3] = '{4'hF, 4'h5, 4'hF};
      logic [31:0] wd  [3] = '{32'h0000_07D1, 32'hAABB_CCDD, 32'hFFFF_FFFF};
      logic [31:0] exd [3] = '{32'h0, 32'h0, 32'h00BB_07DD};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 3) begin
            drive(0, 1'b1, we[k], 12'd256, be[k], wd[k]);
            void'(model_apply(0, we[k], 12'd256, be[k], wd[k]));
         end else drive(0, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
         #1;
         checks++;
         if (k >= 1 && k <= 3) begin
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== exd[k-1] || rsp_err[0] !== 1'b0) begin
               errors++;
               $display("FAIL byte_lane[%0d] got v=%0b d=%h e=%0b exp v=1 d=%h e=0", k, rsp_valid[0], rsp_data[0], rsp_err[0], exd[k-1]);
            end
         end else if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL byte_lane_idle[%0d] got v=%0b exp v=0", k, rsp_valid[0]);
         end
      end
   endtask

   task automatic test_range();
      logic        we  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [11:0] ad  [4] = '{12'd255, 12'd1280, 12'd1279, 12'd256};
      logic        exe [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] exd [4] = '{32'h0, 32'h0, 32'h0, 32'h00BB_07DD};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 4) begin
            drive(0, 1'b1, we[k], ad[k], 4'hF, 32'hDEAD_BEEF);
            void'(model_apply(0, we[k], ad[k], 4'hF, 32'hDEAD_BEEF));
         end else drive(0, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
         #1;
         checks++;
         if (k >= 1 && k <= 4) begin
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== exd[k-1] || rsp_err[0] !== exe[k-1]) begin
               errors++;
               $display("FAIL range[%0d] got v=%0b d=%h e=%0b exp v=1 d=%h e=%0b", k, rsp_valid[0], rsp_data[0], rsp_err[0], exd[k-1], exe[k-1]);
            end
         end else if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL range_idle[%0d] got v=%0b exp v=0", k, rsp_valid[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic        we  [3] = '{1'b1, 1'b0, 1'b0};
      logic [11:0] ad  [3] = '{12'd257, 12'd257, 12'd258};
      logic [31:0] exd [3] = '{32'h0, 32'h0000_0FA1, 32'h0};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 3) begin
            drive(1, 1'b1, we[k], ad[k], 4'hF, 32'h0000_0FA1);
            void'(model_apply(1, we[k], ad[k], 4'hF, 32'h0000_0FA1));
         end else drive(1, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
         #1;
         checks++;
         if (k >= 2 && k <= 4) begin
            if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== exd[k-2] || rsp_err[1] !== 1'b0) begin
               errors++;
               $display("FAIL b2b[%0d] got v=%0b d=%h e=%0b exp v=1 d=%h e=0", k, rsp_valid[1], rsp_data[1], rsp_err[1], exd[k-2]);
            end
         end else if (rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle[%0d] got v=%0b exp v=0", k, rsp_valid[1]);
         end
      end
   endtask

   task automatic test_random(input int d, input int n);
      exp_t        q [$];
      exp_t        e;
      logic [32:0] r;
      int          lat;
      lat = (d == 1) ? 2 : 1;
      for (int c = 0; c < n + lat + 2; c++) begin
         logic [11:0] a;
         int          sel;
         @(negedge clk);
         sel = $urandom_range(0, 3);
         case (sel)
            0: a = 12'(256 + $urandom_range(0, 15));
            1: a = 12'($urandom_range(0, 4095));
            2: a = ($urandom_range(0, 1) == 0) ? 12'(255 + $urandom_range(0, 1)) : 12'(1279 + $urandom_range(0, 1));
            default: a = 12'($urandom_range(250, 1290));
         endcase
         if (c < n && $urandom_range(0, 3) != 0)
            drive(d, 1'b1, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
         else
            drive(d, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
         #1;
         checks++;
         if (q.size() > 0 && q[0].due == c) begin
            e = q.pop_front();
            if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== e.data || rsp_err[d] !== e.err) begin
               errors++;
               $display("FAIL random[%0d] cyc %0d got v=%0b d=%h e=%0b exp v=1 d=%h e=%0b", d, c, rsp_valid[d], rsp_data[d], rsp_err[d], e.data, e.err);
            end
         end else if (rsp_valid[d] !== 1'b0 || rsp_data[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
            errors++;
            $display("FAIL random_idle[%0d] cyc %0d got v=%0b d=%h e=%0b exp all 0", d, c, rsp_valid[d], rsp_data[d], rsp_err[d]);
         end
         checks++;
         if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL random_ready[%0d] cyc %0d got %0b exp 1", d, c, req_ready[d]);
         end
         if (req_valid[d] && req_ready[d]) begin
            r = model_apply(d, req_we[d], req_addr[d], req_be[d], req_wdata[d]);
            e.due  = c + lat;
            e.err  = r[32];
            e.data = r[31:0];
            q.push_back(e);
         end
      end
   endtask

   task automatic test_mid_sweep_reset();
      int cnt;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 12'd1279, 4'hF, 32'h5A5A_5A5A);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      cnt = 0;
      for (int c = 0; c < 500; c++) begin
         #1;
         if (init_busy[0] && !req_ready[0]) cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt !== 500) begin
         errors++;
         $display("FAIL partial_sweep got %0d busy cycles exp 500", cnt);
      end
      rst[0] = 1'b1;
      #1;
      checks++;
      if (init_busy[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_sweep_rst got busy=%0b rdy=%0b exp busy=1 rdy=0", init_busy[0], req_ready[0]);
      end
      @(negedge clk);
      rst[0] = 1'b0;
      cnt = 0;
      for (int c = 0; c < 2000; c++) begin
         #1;
         if (init_busy[0] && !req_ready[0]) cnt++;
         else break;
         @(negedge clk);
      end
      checks++;
      if (cnt !== 1024) begin
         errors++;
         $display("FAIL restart_sweep got %0d busy cycles exp 1024", cnt);
      end
      for (int i = 0; i < 1024; i++) mem_m[0][i] = 32'h0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 12'd1279, 4'h0, 32'h0);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      #1;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'h0) begin
         errors++;
         $display("FAIL sweep_cleared got v=%0b d=%h exp v=1 d=00000000", rsp_valid[0], rsp_data[0]);
      end
   endtask

   task automatic test_reset_run();
      logic [11:0] ad  [2] = '{12'd300, 12'd1279};
      logic [31:0] exd [2] = '{32'h1234_5678, 32'hCAFE_F00D};
      @(negedge clk);
      drive(2, 1'b1, 1'b1, 12'd300, 4'hF, 32'h1234_5678);
      @(negedge clk);
      drive(2, 1'b1, 1'b1, 12'd1279, 4'hF, 32'hCAFE_F00D);
      @(negedge clk);
      drive(2, 1'b1, 1'b0, 12'd300, 4'h0, 32'h0);
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      rst[2] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) rst[2] = 1'b0;
         #1;
         checks++;
         if (rsp_valid[2] !== 1'b0 || rsp_data[2] !== 32'h0) begin
            errors++;
            $display("FAIL abort_rsp[%0d] got v=%0b d=%h exp v=0 d=0", k, rsp_valid[2], rsp_data[2]);
         end
         if (k >= 3) begin
            checks++;
            if (req_ready[2] !== 1'b1 || init_busy[2] !== 1'b0) begin
               errors++;
               $display("FAIL noclr_run[%0d] got rdy=%0b busy=%0b exp rdy=1 busy=0", k, req_ready[2], init_busy[2]);
            end
         end
         @(negedge clk);
      end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         if (k < 2) drive(2, 1'b1, 1'b0, ad[k], 4'h0, 32'h0);
         else drive(2, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
         #1;
         if (k >= 1) begin
            checks++;
            if (rsp_valid[2] !== 1'b1 || rsp_data[2] !== exd[k-1] || rsp_err[2] !== 1'b0) begin
               errors++;
               $display("FAIL preserved[%0d] got v=%0b d=%h e=%0b exp v=1 d=%h e=0", k, rsp_valid[2], rsp_data[2], rsp_err[2], exd[k-1]);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      rst = 3'b111;
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
      test_reset();
      test_sweep();
      test_byte_lane();
      test_range();
      test_back_to_back();
      test_random(0, 300);
      test_random(1, 300);
      test_mid_sweep_reset();
      test_reset_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/datamemory_param.md
DATAMEMORY_PARAM -- requirements
Module: datamemory_param

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32: word width; multiple of 8.
- DEPTH, 1024: number of words.
- ADDR_W, 12: request word-address width.
- BASE_ADDR, 256: lowest mapped word address.
- RD_LAT, 1: response latency in cycles; 1 or 2.
- CLEAR_ON_RESET, 1: 1 = zero-fill sweep after reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: block accepts a request this cycle.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: word address.
- req_be, in, DATA_W/8: byte-lane write enables.
- req_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: one-cycle response strobe.
- rsp_data, out, DATA_W: read data; 0 for writes.
- rsp_err, out, 1: address out of range.
- init_busy, out, 1: clear sweep in progress.

Function
REQ-003 A request SHALL be accepted in a cycle where req_valid=1 and req_ready=1; at most one request is accepted per cycle.
REQ-004 The storage index SHALL be req_addr-BASE_ADDR; an address is in range iff BASE_ADDR <= req_addr < BASE_ADDR+DEPTH, compared unsigned at ADDR_W bits.
REQ-005 An accepted in-range write SHALL update only the byte lanes with req_be[i]=1, at the clock edge of acceptance; lanes with req_be[i]=0 keep their old value.
REQ-006 Every accepted request, read or write, SHALL produce exactly one rsp_valid pulse RD_LAT cycles after the acceptance edge; responses SHALL appear in acceptance order.
REQ-007 A read response SHALL return the word contents after all writes accepted in earlier cycles; req_be is ignored on reads.
REQ-008 A write response SHALL have rsp_data=0.
REQ-009 An out-of-range request SHALL leave memory unchanged; its response SHALL have rsp_err=1 and rsp_data=0.
REQ-010 rsp_data and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-011 The response path SHALL have no back-pressure; the pipeline SHALL sustain one request per cycle.
REQ-012 The FSM SHALL have states CLEAR and RUN.
REQ-013 In CLEAR, a counter SHALL write 0 to index 0..DEPTH-1, one word per cycle, with init_busy=1 and req_ready=0; after index DEPTH-1 is written the FSM SHALL move to RUN.
REQ-014 In RUN, req_ready SHALL be 1 and init_busy SHALL be 0.
REQ-015 If CLEAR_ON_RESET=0, reset SHALL enter RUN directly and memory contents SHALL be preserved across reset.

Reset
REQ-016 While rst=1:
- rsp_valid, rsp_err, rsp_data and req_ready SHALL be 0.
- In-flight responses SHALL be discarded.
- The sweep counter SHALL be 0.
REQ-017 After rst falls, the FSM SHALL be in CLEAR (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0).
REQ-018 Reset asserted during CLEAR SHALL restart the sweep from index 0.
REQ-019 Reset asserted during RUN SHALL abort pending responses, with no rsp_valid for requests accepted before reset.

Verification
REQ-020 Sweep timing: defaults, rst released -> init_busy=1 and req_ready=0 for exactly 1024 cycles, then req_ready=1; a read of address 256 returns 0x00000000.
REQ-021 Byte-lane write:
- write 0x000007D1 to address 256 with be=1111;
- then write 0xAABBCCDD to address 256 with be=0101;
- then read address 256 -> 0x00BB07DD, rsp_err=0, exactly 1 cycle after acceptance.
REQ-022 Range bounds:
- read address 255 -> rsp_err=1, rsp_data=0;
- write to address 1280 -> rsp_err=1;
- read address 1279 -> in range, rsp_err=0;
- memory is unchanged afterwards.
REQ-023 Back-to-back at RD_LAT=2:
- accepted sequence write 0x00000FA1 to 257, read 257, read 258 on consecutive cycles;
- -> three consecutive rsp_valid pulses, rsp_data 0, 0x00000FA1, 0, each 2 cycles after its acceptance.
REQ-024 Mid-sweep reset: rst pulsed at sweep cycle 500 -> init_busy stays 1 and the full 1024-cycle sweep restarts.
REQ-025 Reset in RUN:
- read accepted, then rst asserted on the next cycle -> no rsp_valid occurs;
- with CLEAR_ON_RESET=0, previously written data is still readable after reset.
